// File: rtl/pixel_tint_pkg.sv
// Shared constants and the intensity-to-channel width expansion for pixel_tint_stage.
package pixel_tint_pkg;

  localparam int unsigned DEF_NUM_CH       = 3;
  localparam int unsigned MODE_GREY_BIT    = DEF_NUM_CH;
  localparam int unsigned DEF_FRAME_PIXELS = 480000;
  localparam int unsigned MAX_W            = 32;
  localparam int unsigned IDX_W            = $clog2(MAX_W);

  // Output bit (ch_w-1-i) takes input bit (in_w-1-(i mod in_w)): truncation when the
  // input is wider, MSB-first replication when it is narrower.
  function automatic logic [MAX_W-1:0] expand(input logic [MAX_W-1:0] din,
                                               input int unsigned in_w,
                                               input int unsigned ch_w);
    logic [MAX_W-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < ch_w) res[IDX_W'(ch_w - 1 - i)] = din[IDX_W'(in_w - 1 - (i % in_w))];
    end
    return res;
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry in-order skid buffer; in_ready and out_valid/out_data come straight from flops.
module skid_buffer
  import pixel_tint_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_count;
  logic             r_ready;

  logic       w_push;
  logic       w_pop;
  logic [1:0] w_count_nxt;

  assign w_push      = in_valid & r_ready;
  assign w_pop       = (r_count != 2'd0) & out_ready;
  assign w_count_nxt = r_count + 2'(w_push) - 2'(w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_ready  <= 1'b1;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= in_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != 2'd2);
    end
  end

  assign in_ready  = r_ready;
  assign out_data  = r_mem[r_rd_ptr];
  assign out_valid = (r_count != 2'd0);

endmodule

// File: rtl/pixel_tint_stage.sv
// Expands intensity samples into tinted colour pixels under a one-hot mode.
// Define PIXEL_TINT_FRAME_SYNC_EN to defer mode changes to the frame wrap.
module pixel_tint_stage
  import pixel_tint_pkg::*;
#(
  parameter int unsigned IN_WIDTH     = 8,
  parameter int unsigned CH_WIDTH     = 8,
  parameter int unsigned NUM_CH       = DEF_NUM_CH,
  parameter int unsigned FRAME_PIXELS = DEF_FRAME_PIXELS
) (
  input  logic                       pixel_clk,
  input  logic                       rst,
  input  logic [IN_WIDTH-1:0]        in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [NUM_CH*CH_WIDTH-1:0] out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic [NUM_CH:0]            mode_sel,
  output logic [NUM_CH:0]            mode_active,
  output logic                       frame_start
);

  localparam int unsigned CNT_W = $clog2(FRAME_PIXELS);
  localparam int unsigned OUT_W = NUM_CH * CH_WIDTH;
  localparam logic [NUM_CH:0] MODE_GREY = {1'b1, {NUM_CH{1'b0}}};

  logic [CNT_W-1:0]    r_pix_cnt;
  logic [NUM_CH:0]     r_mode_pending;
  logic [NUM_CH:0]     r_mode_active;

  logic                w_in_fire;
  logic                w_cnt_last;
  logic [NUM_CH:0]     w_mode_req;
  logic [NUM_CH:0]     w_pending_nxt;
  logic [CH_WIDTH-1:0] w_val;
  logic [OUT_W-1:0]    w_tint;

  assign w_in_fire  = in_valid & in_ready;
  assign w_cnt_last = (r_pix_cnt == CNT_W'(FRAME_PIXELS - 1));

  // Highest set request bit wins, so grey beats any channel on a tie.
  always_comb begin
    w_mode_req = '0;
    for (int k = 0; k <= NUM_CH; k++) begin
      if (mode_sel[k]) begin
        w_mode_req    = '0;
        w_mode_req[k] = 1'b1;
      end
    end
  end

  assign w_pending_nxt = (|mode_sel) ? w_mode_req : r_mode_pending;
  assign w_val         = CH_WIDTH'(expand(MAX_W'(in_data), IN_WIDTH, CH_WIDTH));

  always_comb begin
    w_tint = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (r_mode_active[NUM_CH] || r_mode_active[ch]) w_tint[ch*CH_WIDTH +: CH_WIDTH] = w_val;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      r_pix_cnt      <= '0;
      r_mode_pending <= MODE_GREY;
      r_mode_active  <= MODE_GREY;
    end else begin
      r_mode_pending <= w_pending_nxt;
      if (w_in_fire) r_pix_cnt <= w_cnt_last ? '0 : r_pix_cnt + 1'b1;
`ifdef PIXEL_TINT_FRAME_SYNC_EN
      if (w_in_fire && w_cnt_last) r_mode_active <= w_pending_nxt;
`else
      if (|mode_sel) r_mode_active <= w_mode_req;
`endif
    end
  end

  assign mode_active = r_mode_active;
  assign frame_start = w_in_fire & (r_pix_cnt == '0) & ~rst;

  skid_buffer #(
    .WIDTH(OUT_W)
  ) u_skid (
    .clk      (pixel_clk),
    .rst      (rst),
    .in_data  (w_tint),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

endmodule

// File: tb/tb_pixel_tint_stage.sv
// Scoreboard bench for pixel_tint_stage: driver predicts tinted pixels, monitor pops and compares.
module tb_pixel_tint_stage;

  localparam int unsigned IN_W  = 8;
  localparam int unsigned CH_W  = 8;
  localparam int unsigned NCH   = 3;
  localparam int unsigned FP    = 16;
  localparam int unsigned OUT_W = NCH * CH_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic [IN_W-1:0]  in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [NCH:0]     mode_sel = '0;
  logic [NCH:0]     mode_active;
  logic             frame_start;

  logic [3:0]       n_in_data = '0;
  logic             n_in_valid = 1'b0;
  logic             n_in_ready;
  logic [OUT_W-1:0] n_out_data;
  logic             n_out_valid;
  logic [NCH:0]     n_mode_active;
  logic             n_frame_start;

  pixel_tint_stage #(
    .IN_WIDTH(IN_W), .CH_WIDTH(CH_W), .NUM_CH(NCH), .FRAME_PIXELS(FP)
  ) u_dut (
    .pixel_clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .mode_sel(mode_sel),
    .mode_active(mode_active), .frame_start(frame_start)
  );

  pixel_tint_stage #(
    .IN_WIDTH(4), .CH_WIDTH(CH_W), .NUM_CH(NCH), .FRAME_PIXELS(FP)
  ) u_dut4 (
    .pixel_clk(clk), .rst(rst), .in_data(n_in_data), .in_valid(n_in_valid),
    .in_ready(n_in_ready), .out_data(n_out_data), .out_valid(n_out_valid),
    .out_ready(1'b1), .mode_sel('0), .mode_active(n_mode_active),
    .frame_start(n_frame_start)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [OUT_W-1:0] sb_q[$];
  int m_active = NCH;
  int m_pending = NCH;
  int m_cnt = 0;
  bit drive_done = 1'b0;
  bit want_rst_chk = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Channel value: keep the top bits, or repeat the sample end to end and keep the top bits.
  function automatic logic [63:0] ref_val(input logic [63:0] v, input int in_w, input int ch_w);
    logic [63:0] rep;
    int reps;
    if (in_w >= ch_w) return v >> (in_w - ch_w);
    rep  = 0;
    reps = (ch_w + in_w - 1) / in_w;
    for (int r = 0; r < reps; r++) rep = (rep << in_w) | v;
    return rep >> (reps * in_w - ch_w);
  endfunction

  function automatic logic [OUT_W-1:0] ref_tint(input logic [63:0] v, input int mode,
                                                input int in_w);
    logic [63:0] c;
    logic [OUT_W-1:0] r;
    c = ref_val(v, in_w, CH_W);
    r = '0;
    for (int ch = 0; ch < NCH; ch++) if (mode == NCH || mode == ch) r |= OUT_W'(c) << (ch * CH_W);
    return r;
  endfunction

  task automatic cycle(input logic v, input logic [IN_W-1:0] d, input logic ordy,
                       input logic [NCH:0] sel, input logic r);
    logic fire;
    int req;
    logic [OUT_W-1:0] exp_t;
    @(negedge clk);
    rst = r; in_valid = v; in_data = d; out_ready = ordy; mode_sel = sel;
    #1;
    if (r) begin
      @(posedge clk);
      sb_q.delete();
      m_cnt = 0; m_active = NCH; m_pending = NCH;
      return;
    end
    if (want_rst_chk) begin
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      want_rst_chk = 1'b0;
    end
    fire = v && in_ready;
    check("mode_active", mode_active, 64'(1) << m_active);
    check("frame_start", frame_start, fire && m_cnt == 0);
    exp_t = ref_tint(64'(d), m_active, IN_W);
    req = -1;
    for (int k = NCH; k >= 0; k--) if (sel[k] && req < 0) req = k;
`ifdef PIXEL_TINT_FRAME_SYNC_EN
    if (req >= 0) m_pending = req;
    if (fire && m_cnt == FP - 1) m_active = m_pending;
`else
    if (req >= 0) begin
      m_pending = req;
      m_active  = req;
    end
`endif
    if (fire) m_cnt = (m_cnt + 1) % FP;
    @(posedge clk);
    if (fire) sb_q.push_back(exp_t);
  endtask

  // Monitor: out_valid/in_ready follow buffer occupancy, held data is stable, pops compare in order.
  initial begin
    logic [OUT_W-1:0] held;
    bit hold;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      #2;
      if (drive_done) break;
      if (rst) begin
        hold = 1'b0;
        continue;
      end
      check("out_valid", out_valid, sb_q.size() != 0);
      check("in_ready", in_ready, sb_q.size() < 2);
      if (hold) check("out_hold", out_data, held);
      hold = out_valid && !out_ready;
      held = out_data;
      if (out_valid && out_ready && sb_q.size() != 0) check("out_data", out_data, sb_q.pop_front());
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 1);
    want_rst_chk = 1'b1;
    cycle(0, 0, 1, 0, 0);

    // Narrow-input instance: 4-bit samples replicate into 8-bit channels.
    #1; n_in_valid = 1'b1; n_in_data = 4'hA;
    @(posedge clk); #1; n_in_valid = 1'b0;
    @(negedge clk); #1;
    check("rep_valid", n_out_valid, 1);
    check("rep_0xA", n_out_data, 24'hAAAAAA);
    n_in_valid = 1'b1; n_in_data = 4'h5;
    @(posedge clk); #1; n_in_valid = 1'b0;
    @(negedge clk); #1;
    check("rep_0x5", n_out_data, 24'h555555);

    for (int v = 0; v < 256; v++) cycle(1, IN_W'(v), 1, 0, 0);

    for (int i = 0; i < 16; i++) cycle(1, IN_W'(8'h40 + i), !(i >= 5 && i < 8), 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0);

    cycle(0, 0, 1, 0, 1);
    for (int i = 0; i < 40; i++) cycle(1, IN_W'($urandom), 1, (i == 5) ? 4'b0100 : 4'b0000, 0);
    for (int i = 0; i < 40; i++) begin
      cycle(1, IN_W'($urandom), 1, (i == 2) ? 4'b0001 : ((i == 20) ? 4'b1001 : 4'b0000), 0);
    end

    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 3) != 0, IN_W'($urandom), $urandom_range(0, 9) < 7,
            ($urandom_range(0, 24) == 0) ? 4'($urandom) : 4'b0000, 0);
    end

    // Mid-frame reset with both buffer entries occupied, non-grey mode pending or active.
    cycle(1, 8'h11, 1, 4'b0010, 0);
    for (int i = 0; i < 3; i++) cycle(1, IN_W'(8'h21 + i), 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    want_rst_chk = 1'b1;
    cycle(0, 0, 1, 0, 0);
    cycle(1, 8'h77, 1, 0, 0);

    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, 0);
    check("drain", sb_q.size(), 0);
    drive_done = 1'b1;
    @(negedge clk); #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
